// File: rtl/mmu_arbiter_pkg.sv
// Shared encodings for the MMU bus arbiter: FSM states, requester IDs and the
// default fairness window.
package mmu_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XLATE = 2'd1,
    S_BUS   = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  localparam int FAIR_LIMIT_DEF = 4;

  // A kernel address touched from user mode, or a mapped address the TLB cannot resolve.
  function automatic logic is_fault(input logic invalid, input logic using_tlb,
                                    input logic miss);
    return invalid | (using_tlb & miss);
  endfunction

endpackage

// File: rtl/mmu_arb_fair.sv
// Anti-starvation override for the arbiter: counts data grants made while a fetch waits
// and hands the next grant to the fetch port once FAIR_LIMIT is reached.
module mmu_arb_fair
  import mmu_arbiter_pkg::*;
#(
  parameter int FAIR_LIMIT = FAIR_LIMIT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_i,
  input  logic   ibus_req_i,
  input  logic   dbus_req_i,
  output owner_e owner_o
);

  localparam int CW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          force_i;

  assign force_i = ibus_req_i && (cnt_q >= CW'(FAIR_LIMIT));

  always_comb begin
    owner_o = OWNER_I;
    if (dbus_req_i && !force_i) begin
      owner_o = OWNER_D;
    end
  end

  // Only IDLE cycles make grants; a fetch grant or an absent fetch ends the streak.
  always_comb begin
    cnt_d = cnt_q;
    if (arb_i) begin
      if (!ibus_req_i || owner_o == OWNER_I) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmu_arbiter.sv
// Shares one address translator and one physical bus between fetch and data ports.
// Optional fetch anti-starvation is enabled with the MMU_ARB_FAIRNESS_EN macro.
module mmu_arbiter
  import mmu_arbiter_pkg::*;
#(
  parameter int FAIR_LIMIT = FAIR_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        user_mode,
  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  output logic [31:0] ibus_rdata,
  output logic        ibus_ack,
  output logic        ibus_err,
  input  logic        dbus_req,
  input  logic        dbus_we,
  input  logic [3:0]  dbus_be,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_ack,
  output logic        dbus_err,
  output logic [31:0] map_addr,
  output logic        map_en,
  input  logic [31:0] map_paddr,
  input  logic        map_invalid,
  input  logic        map_using_tlb,
  input  logic        map_uncached,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_uncached,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  state_e      state_q;
  owner_e      owner_q;
  owner_e      grant_owner;
  logic [31:0] addr_q, wdata_q, paddr_q, irdata_q, drdata_q;
  logic [3:0]  be_q;
  logic        we_q, uncached_q, map_en_q, bus_req_q;
  logic        iack_q, dack_q, ierr_q, derr_q;
  logic        any_req, xlate_fault;
  logic        unused_user;

  assign any_req     = ibus_req | dbus_req;
  assign xlate_fault = is_fault(map_invalid, map_using_tlb, tlb_miss);
  // Privilege is already folded into map_invalid by the translator.
  assign unused_user = user_mode;

`ifdef MMU_ARB_FAIRNESS_EN
  mmu_arb_fair #(
    .FAIR_LIMIT (FAIR_LIMIT)
  ) u_fair (
    .clk        (clk),
    .rst        (rst),
    .arb_i      (state_q == S_IDLE),
    .ibus_req_i (ibus_req),
    .dbus_req_i (dbus_req),
    .owner_o    (grant_owner)
  );
`else
  logic unused_limit;
  assign unused_limit = ^FAIR_LIMIT;
  assign grant_owner  = dbus_req ? OWNER_D : OWNER_I;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWNER_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      paddr_q    <= '0;
      uncached_q <= 1'b0;
      map_en_q   <= 1'b0;
      bus_req_q  <= 1'b0;
      iack_q     <= 1'b0;
      dack_q     <= 1'b0;
      ierr_q     <= 1'b0;
      derr_q     <= 1'b0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      map_en_q <= 1'b0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      ierr_q   <= 1'b0;
      derr_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= grant_owner;
            if (grant_owner == OWNER_D) begin
              addr_q  <= dbus_addr;
              we_q    <= dbus_we;
              be_q    <= dbus_be;
              wdata_q <= dbus_wdata;
            end else begin
              addr_q  <= ibus_addr;
              we_q    <= 1'b0;
              be_q    <= 4'hF;
              wdata_q <= '0;
            end
            map_en_q <= 1'b1;
            state_q  <= S_XLATE;
          end
        end
        S_XLATE: begin
          paddr_q    <= map_using_tlb ? tlb_paddr : map_paddr;
          uncached_q <= map_uncached;
          if (xlate_fault) begin
            // Faults skip the bus entirely and answer straight away.
            iack_q  <= (owner_q == OWNER_I);
            dack_q  <= (owner_q == OWNER_D);
            ierr_q  <= (owner_q == OWNER_I);
            derr_q  <= (owner_q == OWNER_D);
            state_q <= S_RESP;
          end else begin
            bus_req_q <= 1'b1;
            state_q   <= S_BUS;
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (!we_q) begin
              if (owner_q == OWNER_I) begin
                irdata_q <= bus_rdata;
              end else begin
                drdata_q <= bus_rdata;
              end
            end
            iack_q  <= (owner_q == OWNER_I);
            dack_q  <= (owner_q == OWNER_D);
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign map_addr     = addr_q;
  assign map_en       = map_en_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = we_q;
  assign bus_be       = be_q;
  assign bus_addr     = paddr_q;
  assign bus_wdata    = wdata_q;
  assign bus_uncached = uncached_q;
  assign ibus_rdata   = irdata_q;
  assign ibus_ack     = iack_q;
  assign ibus_err     = ierr_q;
  assign dbus_rdata   = drdata_q;
  assign dbus_ack     = dack_q;
  assign dbus_err     = derr_q;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter: a small kseg/TLB translator model and a bus responder
// surround the DUT; each scenario task checks its own hand-computed results.
module tb_mmu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        user_mode;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic [31:0] ibus_rdata;
  logic        ibus_ack, ibus_err;
  logic        dbus_req, dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic        dbus_ack, dbus_err;
  logic [31:0] map_addr, map_paddr, tlb_paddr;
  logic        map_en, map_invalid, map_using_tlb, map_uncached, tlb_miss;
  logic        bus_req, bus_we, bus_uncached, bus_ack;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          bus_req_cnt, map_en_cnt;
  logic        bus_hold;
  logic [31:0] rd_val;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we, seen_unc;

  mmu_arbiter dut (
    .clk(clk), .rst(rst), .user_mode(user_mode),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_rdata(ibus_rdata),
    .ibus_ack(ibus_ack), .ibus_err(ibus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
    .map_addr(map_addr), .map_en(map_en), .map_paddr(map_paddr), .map_invalid(map_invalid),
    .map_using_tlb(map_using_tlb), .map_uncached(map_uncached),
    .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_uncached(bus_uncached), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  // Translator model: kuseg is TLB-mapped, kseg0/kseg1 strip the top three bits.
  assign map_using_tlb = ~map_addr[31];
  assign map_paddr     = {3'b000, map_addr[28:0]};
  assign map_uncached  = (map_addr[31:29] == 3'b101);
  assign map_invalid   = user_mode & map_addr[31];

  // Bus responder: acks in the first cycle bus_req is seen unless held off.
  initial begin
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_req) bus_req_cnt++;
      if (map_en) map_en_cnt++;
      if (bus_req && !bus_hold) begin
        bus_ack = 1'b1;
        bus_rdata = rd_val;
        seen_addr = bus_addr;
        seen_we = bus_we;
        seen_be = bus_be;
        seen_wdata = bus_wdata;
        seen_unc = bus_uncached;
      end else begin
        bus_ack = 1'b0;
        bus_rdata = 32'h0BAD_0BAD;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input int budget, output int cyc, output logic ia, output logic da,
                          output logic ie, output logic de);
    int i;
    i = 0;
    cyc = -1;
    ia = 1'b0; da = 1'b0; ie = 1'b0; de = 1'b0;
    while (cyc < 0 && i < budget) begin
      @(negedge clk);
      i++;
      if (ibus_ack || dbus_ack) begin
        cyc = i;
        ia = ibus_ack; da = dbus_ack; ie = ibus_err; de = dbus_err;
      end
    end
  endtask

  task automatic test_reset;
    ibus_req = 1'b1;
    ibus_addr = 32'h8000_1000;
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if ({bus_req, map_en, ibus_ack, dbus_ack, ibus_err, dbus_err, bus_we, bus_uncached} !== 8'h00) begin
        n_fail++; $display("FAIL rst_ctl: got %b want 00000000", {bus_req, map_en, ibus_ack, dbus_ack, ibus_err, dbus_err, bus_we, bus_uncached}); end
    end
    n_cmp++; if (bus_addr !== 32'h0 || map_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_addr: bus_addr %h map_addr %h want 0", bus_addr, map_addr); end
    n_cmp++; if (ibus_rdata !== 32'h0 || dbus_rdata !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_data: irdata %h drdata %h be %h wdata %h want 0", ibus_rdata, dbus_rdata, bus_be, bus_wdata); end
    ibus_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_ibus_read;
    int cyc; logic ia, da, ie, de;
    @(negedge clk);
    bus_req_cnt = 0; map_en_cnt = 0;
    rd_val = 32'hDEAD_BEEF;
    ibus_addr = 32'h8000_1000;
    ibus_req = 1'b1;
    wait_ack(10, cyc, ia, da, ie, de);
    ibus_req = 1'b0;
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL ird_lat: got %0d want 3", cyc); end
    n_cmp++; if ({ia, da, ie, de} !== 4'b1000) begin n_fail++; $display("FAIL ird_flags: got %b want 1000", {ia, da, ie, de}); end
    n_cmp++; if (ibus_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ird_data: got %h want deadbeef", ibus_rdata); end
    n_cmp++; if (seen_addr !== 32'h0000_1000 || seen_unc !== 1'b0) begin
      n_fail++; $display("FAIL ird_bus: addr %h unc %b want 00001000 0", seen_addr, seen_unc); end
    n_cmp++; if (bus_req_cnt !== 1 || map_en_cnt !== 1) begin
      n_fail++; $display("FAIL ird_pulses: bus_req %0d map_en %0d cycles want 1 1", bus_req_cnt, map_en_cnt); end
  endtask

  task automatic test_back_to_back;
    int cyc; logic ia, da, ie, de;
    @(negedge clk);
    rd_val = 32'hDEAD_BEEF;
    dbus_addr = 32'hA000_0010; dbus_we = 1'b1; dbus_be = 4'hF; dbus_wdata = 32'h1234_5678;
    ibus_addr = 32'h9000_2000;
    dbus_req = 1'b1; ibus_req = 1'b1;
    wait_ack(10, cyc, ia, da, ie, de);
    dbus_req = 1'b0;
    n_cmp++; if (cyc !== 3 || {ia, da, ie, de} !== 4'b0100) begin
      n_fail++; $display("FAIL b2b_dfirst: lat %0d flags %b want 3 0100", cyc, {ia, da, ie, de}); end
    n_cmp++; if (seen_addr !== 32'h0000_0010 || seen_we !== 1'b1 || seen_unc !== 1'b1) begin
      n_fail++; $display("FAIL b2b_dbus: addr %h we %b unc %b want 00000010 1 1", seen_addr, seen_we, seen_unc); end
    n_cmp++; if (seen_wdata !== 32'h1234_5678 || seen_be !== 4'hF) begin
      n_fail++; $display("FAIL b2b_wr: wdata %h be %h want 12345678 f", seen_wdata, seen_be); end
    n_cmp++; if (dbus_rdata !== 32'h0) begin n_fail++; $display("FAIL b2b_wr_rdata: got %h want 0", dbus_rdata); end
    rd_val = 32'hCAFE_F00D;
    wait_ack(10, cyc, ia, da, ie, de);
    ibus_req = 1'b0;
    n_cmp++; if (cyc !== 4 || {ia, da, ie, de} !== 4'b1000) begin
      n_fail++; $display("FAIL b2b_inext: lat %0d flags %b want 4 1000", cyc, {ia, da, ie, de}); end
    n_cmp++; if (ibus_rdata !== 32'hCAFE_F00D || seen_addr !== 32'h1000_2000 || seen_we !== 1'b0 || seen_unc !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ibus: rdata %h addr %h we %b unc %b want cafef00d 10002000 0 0", ibus_rdata, seen_addr, seen_we, seen_unc); end
  endtask

  task automatic test_priv_fault;
    int cyc; logic ia, da, ie, de;
    @(negedge clk);
    bus_req_cnt = 0;
    user_mode = 1'b1;
    dbus_addr = 32'h8000_0000; dbus_we = 1'b0; dbus_be = 4'hF;
    dbus_req = 1'b1;
    wait_ack(10, cyc, ia, da, ie, de);
    dbus_req = 1'b0;
    user_mode = 1'b0;
    n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL prv_lat: got %0d want 2", cyc); end
    n_cmp++; if ({ia, da, ie, de} !== 4'b0101) begin n_fail++; $display("FAIL prv_flags: got %b want 0101", {ia, da, ie, de}); end
    n_cmp++; if (bus_req_cnt !== 0 || dbus_rdata !== 32'h0) begin
      n_fail++; $display("FAIL prv_nobus: bus_req %0d cycles rdata %h want 0 0", bus_req_cnt, dbus_rdata); end
  endtask

  task automatic test_tlb;
    int cyc; logic ia, da, ie, de;
    @(negedge clk);
    bus_req_cnt = 0;
    tlb_miss = 1'b1;
    ibus_addr = 32'h0040_0000;
    ibus_req = 1'b1;
    wait_ack(10, cyc, ia, da, ie, de);
    ibus_req = 1'b0;
    n_cmp++; if (cyc !== 2 || {ia, da, ie, de} !== 4'b1010) begin
      n_fail++; $display("FAIL tlb_miss: lat %0d flags %b want 2 1010", cyc, {ia, da, ie, de}); end
    n_cmp++; if (bus_req_cnt !== 0 || ibus_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL tlb_miss_side: bus_req %0d rdata %h want 0 cafef00d", bus_req_cnt, ibus_rdata); end
    @(negedge clk);
    tlb_miss = 1'b0;
    tlb_paddr = 32'h0100_0000;
    rd_val = 32'h55AA_1234;
    ibus_req = 1'b1;
    wait_ack(10, cyc, ia, da, ie, de);
    ibus_req = 1'b0;
    n_cmp++; if (cyc !== 3 || {ia, da, ie, de} !== 4'b1000) begin
      n_fail++; $display("FAIL tlb_hit: lat %0d flags %b want 3 1000", cyc, {ia, da, ie, de}); end
    n_cmp++; if (seen_addr !== 32'h0100_0000 || ibus_rdata !== 32'h55AA_1234) begin
      n_fail++; $display("FAIL tlb_hit_data: addr %h rdata %h want 01000000 55aa1234", seen_addr, ibus_rdata); end
  endtask

  task automatic test_fairness;
    int cyc; logic ia, da, ie, de;
    logic [5:0] exp_d;
`ifdef MMU_ARB_FAIRNESS_EN
    exp_d = 6'b101111;
`else
    exp_d = 6'b111111;
`endif
    @(negedge clk);
    dbus_addr = 32'h8000_0040; dbus_we = 1'b0;
    ibus_addr = 32'h8000_1000;
    dbus_req = 1'b1; ibus_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(12, cyc, ia, da, ie, de);
      n_cmp++; if (da !== exp_d[k] || ia !== !exp_d[k]) begin
        n_fail++; $display("FAIL fair_grant%0d: ibus_ack %b dbus_ack %b want dbus %b", k, ia, da, exp_d[k]); end
      n_cmp++; if (cyc !== ((k == 0) ? 3 : 4)) begin
        n_fail++; $display("FAIL fair_lat%0d: got %0d want %0d", k, cyc, (k == 0) ? 3 : 4); end
    end
    dbus_req = 1'b0; ibus_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc, i, acks; logic ia, da, ie, de;
    @(negedge clk);
    bus_hold = 1'b1;
    dbus_addr = 32'h8000_0080; dbus_we = 1'b0;
    dbus_req = 1'b1;
    i = 0;
    while (!bus_req && i < 10) begin @(negedge clk); i++; end
    n_cmp++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rmid_busreq: got %b want 1", bus_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus_req, map_en, ibus_ack, dbus_ack} !== 4'b0000 || dbus_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rmid_drop: req/en/iack/dack %b rdata %h want 0000 0", {bus_req, map_en, ibus_ack, dbus_ack}, dbus_rdata); end
    dbus_req = 1'b0;
    acks = 0;
    repeat (3) begin @(negedge clk); if (ibus_ack || dbus_ack || bus_req) acks++; end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d active cycles want 0", acks); end
    rst = 1'b0;
    bus_hold = 1'b0;
    rd_val = 32'h0F0F_0F0F;
    dbus_addr = 32'hA000_0080;
    dbus_req = 1'b1;
    wait_ack(10, cyc, ia, da, ie, de);
    dbus_req = 1'b0;
    n_cmp++; if (cyc !== 3 || {ia, da, ie, de} !== 4'b0100) begin
      n_fail++; $display("FAIL rmid_fresh: lat %0d flags %b want 3 0100", cyc, {ia, da, ie, de}); end
    n_cmp++; if (dbus_rdata !== 32'h0F0F_0F0F || seen_addr !== 32'h0000_0080 || seen_unc !== 1'b1) begin
      n_fail++; $display("FAIL rmid_data: rdata %h addr %h unc %b want 0f0f0f0f 00000080 1", dbus_rdata, seen_addr, seen_unc); end
  endtask

  initial begin
    rst = 1'b1;
    user_mode = 1'b0;
    ibus_req = 1'b0; ibus_addr = '0;
    dbus_req = 1'b0; dbus_we = 1'b0; dbus_be = '0; dbus_addr = '0; dbus_wdata = '0;
    tlb_paddr = '0; tlb_miss = 1'b0;
    bus_hold = 1'b0; rd_val = '0;
    bus_req_cnt = 0; map_en_cnt = 0;
    seen_addr = '0; seen_wdata = '0; seen_be = '0; seen_we = 1'b0; seen_unc = 1'b0;
    test_reset();
    test_ibus_read();
    test_back_to_back();
    test_priv_fault();
    test_tlb();
    test_fairness();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_arbiter.md
MMU_ARBITER -- requirements
Module: mmu_arbiter

Interface
REQ-001 SHALL have parameter: FAIR_LIMIT, 4, consecutive data grants allowed while an instruction request waits (only used with MMU_ARB_FAIRNESS_EN).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- user_mode  in  1  CPU in user mode.
- ibus_req  in  1  fetch request.
- ibus_addr  in  32  fetch virtual address.
- ibus_rdata  out  32  fetch data.
- ibus_ack  out  1  fetch done pulse.
- ibus_err  out  1  fetch fault, with ack.
- dbus_req  in  1  data request.
- dbus_we  in  1  data write.
- dbus_be  in  4  byte enables.
- dbus_addr  in  32  data virtual address.
- dbus_wdata  in  32  write data.
- dbus_rdata  out  32  read data.
- dbus_ack  out  1  data done pulse.
- dbus_err  out  1  data fault, with ack.
- map_addr  out  32  virtual address to translator.
- map_en  out  1  translator access enable.
- map_paddr  in  32  kseg0/kseg1 physical address.
- map_invalid  in  1  user access to kernel space.
- map_using_tlb  in  1  address is TLB-mapped.
- map_uncached  in  1  kseg1 access.
- tlb_paddr  in  32  TLB physical address, same cycle as map_addr.
- tlb_miss  in  1  TLB lookup failed.
- bus_req  out  1  physical bus request.
- bus_we  out  1  bus write.
- bus_be  out  4  bus byte enables.
- bus_addr  out  32  physical address.
- bus_wdata  out  32  bus write data.
- bus_uncached  out  1  uncached attribute.
- bus_rdata  in  32  bus read data.
- bus_ack  in  1  bus completion, one cycle.

Function
REQ-003 SHALL share one translator and one bus between the ibus and dbus requesters, one transaction at a time.
REQ-004 SHALL implement FSM IDLE -> XLATE -> BUS -> RESP -> IDLE; XLATE -> RESP directly on fault.
REQ-005 IDLE: if any req is high, SHALL select the owner and latch its addr/we/be/wdata; data wins over instruction; with no req, stay IDLE.
REQ-006 XLATE: SHALL drive map_addr from the latch with map_en=1 for exactly one cycle, then register the outcome.
- Physical address = tlb_paddr if map_using_tlb, else map_paddr.
- Fault = map_invalid | (map_using_tlb & tlb_miss).
REQ-007 BUS: SHALL hold bus_req=1 and stable bus_* until bus_ack; on bus_ack, capture bus_rdata (reads only) and go to RESP.
REQ-008 RESP: SHALL pulse the owner's ack for exactly one cycle, with rdata valid and err = fault; the other requester's ack/err stay 0.
REQ-009 Minimum latency SHALL be 3 cycles from sampled req to ack (bus_ack in the first BUS cycle); faults SHALL ack after 2 cycles without asserting bus_req.
REQ-010 Requesters SHALL hold req and operands until ack (no cancellation); a req still high after ack SHALL be treated as a new transaction, re-arbitrated in the next IDLE cycle.
REQ-011 rdata SHALL hold its last value until the next ack to the same port; writes SHALL leave rdata unchanged.
REQ-012 bus_ack outside BUS SHALL be ignored.
REQ-013 map_en, bus_req, ibus_ack and dbus_ack SHALL be registered (glitch-free).

Reset
REQ-014 While rst=1, all outputs SHALL be 0, the FSM SHALL be IDLE, and latches and the fairness counter SHALL be 0.
REQ-015 Reset asserted mid-transaction SHALL immediately drop bus_req and abort the transaction with no ack; the first arbitration SHALL happen in the first clk edge after rst falls.

Configuration
REQ-016 Macro MMU_ARB_FAIRNESS_EN defined:
- A counter SHALL count consecutive dbus grants made while ibus_req is high.
- At FAIR_LIMIT, the next grant SHALL go to ibus if ibus_req is high, then the counter clears.
- An ibus grant, or ibus_req low in IDLE, SHALL also clear the counter.
REQ-017 Macro undefined: strict data priority; no counter logic.

Structure
REQ-018 A shared package/header SHALL hold the FSM state encodings (2-bit), the owner encoding (OWNER_I=0, OWNER_D=1) and the FAIR_LIMIT default.
REQ-019 The fairness logic SHALL be one sub-module, mmu_arb_fair (counter plus grant override), instantiated only under MMU_ARB_FAIRNESS_EN; the FSM stays in mmu_arbiter.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ibus read 0x8000_1000, map_paddr=0x0000_1000, bus_ack first BUS cycle, bus_rdata=0xDEAD_BEEF -> bus_addr=0x0000_1000, bus_uncached=0, ibus_ack at cycle 3, ibus_rdata=0xDEAD_BEEF.
- Simultaneous ibus+dbus, dbus write 0xA000_0010 wdata=0x1234_5678 be=0xF -> dbus first, bus_uncached=1, bus_we=1; ibus serviced next, acked in the next transaction (no cycles wasted in IDLE).
- user_mode=1, dbus 0x8000_0000, map_invalid=1 -> dbus_ack+dbus_err at cycle 2, bus_req never 1.
- ibus 0x0040_0000, map_using_tlb=1, tlb_miss=1 -> ibus_err; then tlb_miss=0, tlb_paddr=0x0100_0000 -> bus_addr=0x0100_0000.
- FAIRNESS_EN, FAIR_LIMIT=4, dbus_req and ibus_req held high -> grants D,D,D,D,I,D…; without macro, ibus never granted.
- rst pulsed while bus_req=1 and bus_ack withheld -> bus_req=0 immediately, no ack; after release, a fresh request completes normally.
